// File: rtl/maxnet_pkg.sv
// maxnet_pkg
// Shared definitions for the MAXNET input loader: state encoding,
// frame size and default word width.
package maxnet_pkg;

    localparam int N_INPUTS       = 4;
    localparam int DEFAULT_DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_FILL   = 2'd0;
    localparam state_t S_LAUNCH = 2'd1;
    localparam state_t S_WAIT   = 2'd2;

endpackage

// File: rtl/maxnet_input_loader_wdog.sv
// loader_wdog
// Done-wait watchdog for the input loader. Counts enabled cycles since the
// last clear and flags the cycle in which the count reaches TIMEOUT_CYCLES.
// Only built when LOADER_TIMEOUT_EN is defined.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the counter (asserted the cycle before counting starts)
//   enable     : count this cycle
//   expired    : high in the enabled cycle that brings the count to TIMEOUT_CYCLES
module loader_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(TIMEOUT_CYCLES))) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of cycles already spent, so the current cycle is
    // the TIMEOUT_CYCLES-th one when count is one short of the limit.
    assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/maxnet_input_loader.sv
// maxnet_input_loader
// Collects four-word frames from a valid/ready stream, presents them on
// x1..x4, launches the controller with a one-cycle start pulse and waits for
// done before accepting the next frame. Short and long frames are dropped
// with a frame_err pulse; a long frame also discards words up to and
// including its in_last.
//
// Optional feature: define LOADER_TIMEOUT_EN to add a done-wait watchdog
// (TIMEOUT_CYCLES); without it timeout is tied low.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : upstream handshake
//   in_data, in_last   : upstream word and end-of-frame marker
//   x1..x4             : buffered frame, stable while busy
//   start              : launch pulse to the controller
//   done               : completion from the controller
//   busy               : high in LAUNCH and WAIT
//   frame_err          : one-cycle pulse after a malformed frame
//   timeout            : one-cycle pulse in the WAIT cycle that expires
//
// state    | meaning
// ---------+-----------------------------------------------
// S_FILL   | accepting words into x[cnt]
// S_LAUNCH | frame complete, start pulsed this cycle
// S_WAIT   | waiting for done (or watchdog expiry)
module maxnet_input_loader
    import maxnet_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic [DATA_W-1:0] x4,
    output logic              start,
    input  logic              done,
    output logic              busy,
    output logic              frame_err,
    output logic              timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state;
    logic [1:0]        cnt;
    logic              discard;
    logic [DATA_W-1:0] xr [N_INPUTS];
    logic              accept;
    logic              wdog_expired;

    assign in_ready = (state == S_FILL);
    assign accept   = in_valid && in_ready;
    assign start    = (state == S_LAUNCH);
    assign busy     = (state == S_LAUNCH) || (state == S_WAIT);

    assign x1 = xr[0];
    assign x2 = xr[1];
    assign x3 = xr[2];
    assign x4 = xr[3];

`ifdef LOADER_TIMEOUT_EN
    loader_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == S_LAUNCH),
        .enable  (state == S_WAIT),
        .expired (wdog_expired)
    );

    // done takes priority over a coinciding expiry.
    assign timeout = (state == S_WAIT) && wdog_expired && !done;
`else
    assign wdog_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FILL;
            cnt       <= '0;
            discard   <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) begin
                xr[i] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        if (discard) begin
                            // Tail of a long frame: drop words through in_last.
                            if (in_last) begin
                                discard <= 1'b0;
                            end
                        end else begin
                            xr[cnt] <= in_data;
                            if (cnt == 2'd3) begin
                                cnt <= '0;
                                if (in_last) begin
                                    state <= S_LAUNCH;
                                end else begin
                                    frame_err <= 1'b1;
                                    discard   <= 1'b1;
                                end
                            end else if (in_last) begin
                                cnt       <= '0;
                                frame_err <= 1'b1;
                            end else begin
                                cnt <= cnt + 2'd1;
                            end
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (done || wdog_expired) begin
                        state <= S_FILL;
                    end
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_input_loader.sv
// tb_maxnet_input_loader
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a frame-level reference model (word queue + phase).
// With LOADER_TIMEOUT_EN defined the watchdog scenarios are exercised too.
module tb_maxnet_input_loader;

    localparam int DW = 8;
    localparam int TO = 10;
`ifdef LOADER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_data;
    logic [DW-1:0] x1, x2, x3, x4;
    logic          start, done, busy, frame_err, timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 = collecting, 1 = launching, 2 = waiting.
    int          m_phase;
    int          m_words[$];
    bit          m_drop;
    logic [DW-1:0] m_x[4];
    bit          m_err;
    int          m_w;          // 1-based WAIT cycle number

    always #5 clk = ~clk;

    maxnet_input_loader #(
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .frame_err (frame_err),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_words.delete();
        m_drop  = 1'b0;
        m_err   = 1'b0;
        m_w     = 0;
        for (int i = 0; i < 4; i++) m_x[i] = '0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit dn);
        bit nerr;
        bit exp_to;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        done     = dn;
        #1;
        exp_to = TO_EN && (m_phase == 2) && (m_w == TO) && !dn;
        chk("in_ready",  in_ready,  m_phase == 0);
        chk("start",     start,     m_phase == 1);
        chk("busy",      busy,      m_phase != 0);
        chk("frame_err", frame_err, m_err);
        chk("timeout",   timeout,   exp_to);
        chk("x1", x1, m_x[0]);
        chk("x2", x2, m_x[1]);
        chk("x3", x3, m_x[2]);
        chk("x4", x4, m_x[3]);

        nerr = 1'b0;
        case (m_phase)
            0: if (v) begin
                if (m_drop) begin
                    if (l) m_drop = 1'b0;
                end else begin
                    m_x[m_words.size()] = d;
                    m_words.push_back(int'(d));
                    if (l) begin
                        if (m_words.size() == 4) m_phase = 1;
                        else nerr = 1'b1;
                        m_words.delete();
                    end else if (m_words.size() == 4) begin
                        nerr   = 1'b1;
                        m_drop = 1'b1;
                        m_words.delete();
                    end
                end
            end
            1: begin
                m_phase = 2;
                m_w     = 1;
            end
            default: begin
                if (dn || (TO_EN && m_w == TO)) m_phase = 0;
                else m_w++;
            end
        endcase
        m_err = nerr;
    endtask

    task automatic frame4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d);
        step(1, a, 0, 0);
        step(1, b, 0, 0);
        step(1, c, 0, 0);
        step(1, d, 1, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        done     = 1'b0;
        model_reset();
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x", {x1, x2, x3, x4}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Good frame, done in the 6th WAIT cycle, then ready again.
        frame4(8'd5, 8'd3, 8'd9, 8'd1);
        step(0, 0, 0, 0);                       // LAUNCH
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);                       // done
        step(0, 0, 0, 0);                       // FILL, in_ready expected
        chk("x_after_frame", {x1, x2, x3, x4}, 32'h05030901);

        // Short frame then a good one.
        step(1, 8'd2, 0, 0);
        step(1, 8'd7, 1, 0);
        step(0, 0, 0, 1);                       // frame_err, done ignored in FILL
        frame4(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        step(0, 0, 0, 1);                       // LAUNCH ignores done
        step(1, 8'hEE, 0, 0);                   // WAIT, valid held: no accept
        step(1, 8'hEF, 1, 0);
        step(1, 8'hF0, 0, 1);
        step(0, 0, 0, 0);

        // Long frame: five words, in_last on the fifth.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        step(1, 8'h55, 1, 0);
        step(0, 0, 0, 0);

`ifdef LOADER_TIMEOUT_EN
        // No done: expiry at WAIT cycle TO.
        frame4(8'h01, 8'h02, 8'h03, 8'h04);
        for (int i = 0; i < TO + 3; i++) step(0, 0, 0, 0);
        // done coinciding with expiry wins.
        frame4(8'h05, 8'h06, 8'h07, 8'h08);
        for (int i = 0; i < TO; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
`endif

        // Reset during the third accept.
        step(1, 8'h61, 0, 0);
        step(1, 8'h62, 0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h63;
        in_last  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_x", {x1, x2, x3, x4}, 0);
        chk("mid_rst_start", start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_frame_err", frame_err, 0);
        chk("mid_rst_timeout", timeout, 0);
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        frame4(8'h71, 8'h72, 8'h73, 8'h74);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit v, l, dn;
            v = ($urandom % 4) != 0;
            if (m_words.size() == 3) l = ($urandom % 6) != 0;
            else                     l = ($urandom % 8) == 0;
            dn = ($urandom % 6) == 0;
            step(v, DW'($urandom), l, dn);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/maxnet_input_loader.md
MAXNET_INPUT_LOADER -- requirements
Module: maxnet_input_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of each input value in bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the done-wait limit; it is used only with LOADER_TIMEOUT_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and in_data (input, DATA_W bits) as the upstream word stream.
REQ-006 The block SHALL have port in_last, input, 1 bit: marks the final word of a frame.
REQ-007 The block SHALL have ports x1, x2, x3, x4, each an output of DATA_W bits, as the buffered frame presented to the controller and datapath.
REQ-008 The block SHALL have port start, output, 1 bit: the launch pulse to the controller.
REQ-009 The block SHALL have port done, input, 1 bit: the completion signal from the controller.
REQ-010 The block SHALL have port busy (output, 1 bit), high in LAUNCH and WAIT.
REQ-011 The block SHALL have port frame_err (output, 1 bit): one-cycle pulse on a malformed frame.
REQ-012 The block SHALL have port timeout (output, 1 bit): one-cycle pulse on done-wait expiry; it is tied to 0 without LOADER_TIMEOUT_EN.

Function
REQ-013 The FSM SHALL have three states: FILL, LAUNCH and WAIT.
REQ-014 in_ready SHALL be 1 only in FILL.
REQ-015 A word SHALL be accepted in any cycle with in_valid and in_ready both high; it is written to x[cnt], then the 2-bit cnt increments.
REQ-016 When the 4th word (cnt=3) is accepted with in_last=1, the FSM SHALL go to LAUNCH and cnt SHALL wrap to 0.
REQ-017 An accepted word with in_last=1 and cnt<3 SHALL be treated as a short frame: pulse frame_err, set cnt to 0, stay in FILL, and leave the partial x values unlaunched.
REQ-018 An accepted 4th word with in_last=0 SHALL be treated as a long frame: pulse frame_err, set cnt to 0, stay in FILL, and discard the following words until and including the next in_last.
REQ-019 In LAUNCH, start SHALL be 1 for exactly one cycle, and the FSM SHALL move to WAIT on the next edge.
REQ-020 x1..x4 SHALL hold stable from the edge entering LAUNCH until the FSM re-enters FILL.
REQ-021 In WAIT, done=1 SHALL move the FSM to FILL on the next edge, with in_ready=1 in that FILL cycle.
REQ-022 done SHALL be ignored in FILL and LAUNCH.
REQ-023 Launch latency from acceptance of the 4th word to start=1 SHALL be 1 cycle.
REQ-024 Minimum frame-to-frame spacing SHALL be 4 accept cycles + 1 LAUNCH cycle + (WAIT cycles until done) + 1.

Reset
REQ-025 On rst_n=0, asynchronously: the state SHALL go to FILL; cnt, x1..x4, start, frame_err, timeout and busy SHALL be 0; and the discard flag SHALL be cleared.
REQ-026 Reset asserted mid-frame or in WAIT SHALL abandon the frame without emitting start or frame_err.

Configuration
REQ-027 With LOADER_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle; when it reaches TIMEOUT_CYCLES without done, the block SHALL pulse timeout and return to FILL.
REQ-028 With LOADER_TIMEOUT_EN undefined, there SHALL be no counter, WAIT SHALL persist until done, and timeout SHALL be 0.
REQ-029 If done and expiry coincide, done SHALL win and timeout SHALL not pulse.

Structure
REQ-030 Shared package maxnet_pkg SHALL hold the state encoding typedef (FILL, LAUNCH, WAIT), the constant N_INPUTS = 4 and the default DATA_W.
REQ-031 The optional watchdog SHALL be sub-module loader_wdog (inputs clear and enable, output expired), instantiated only under LOADER_TIMEOUT_EN.

Verification
REQ-032 Stream 5, 3, 9, 1 (in_last on 1), done after 6 WAIT cycles -> x = 5/3/9/1, a single start pulse 1 cycle after the 4th accept, in_ready=1 the cycle after done.
REQ-033 Stream 2, 7 with in_last on 7 -> frame_err pulses, no start, cnt=0; a following good frame launches normally.
REQ-034 Five words with in_last on the 5th -> frame_err at the 4th word, 5th discarded, no start.
REQ-035 in_valid held high through WAIT -> no accepts while busy=1, and x stays unchanged.
REQ-036 With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=10, no done -> timeout pulses at WAIT cycle 10, then FILL; a done coinciding at cycle 10 -> no timeout.
REQ-037 rst_n low during the 3rd accept -> all outputs 0 immediately; a new 4-word frame after release launches correctly.
